// File: rtl/vram_pkg.sv
// Shared defaults and state encoding for the line-packing VRAM.
package vram_pkg;

  localparam int VRAM_WORD_W         = 16;
  localparam int VRAM_WORDS_PER_LINE = 16;
  localparam int VRAM_LINES          = 2048;

  typedef enum logic [1:0] {
    PK_IDLE,
    PK_FILL,
    PK_COMMIT
  } packer_state_t;

endpackage

// File: rtl/vram_word_bank.sv
// One word column of the line store: simple dual-port RAM, one write port and a
// registered read-first read port whose output register clears on reset.
module vram_word_bank #(
  parameter  int WORD_W  = 16,
  parameter  int LINES   = 2048,
  localparam int LADDR_W = $clog2(LINES)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [LADDR_W-1:0] waddr,
  input  logic [WORD_W-1:0]  wdata,
  input  logic [LADDR_W-1:0] raddr,
  output logic [WORD_W-1:0]  rdata
);

  logic [WORD_W-1:0] mem [LINES];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // read stage: old contents are returned when the same line is written this edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata <= '0;
    else     rdata <= mem[raddr];
  end

endmodule

// File: rtl/vram_line_packer_memory.sv
// Line-wide VRAM: gathers addressed word writes into a line buffer and commits
// the written words of that line in one cycle; one whole line is read per clock.
module vram_line_packer_memory
  import vram_pkg::*;
#(
  parameter  int WORD_W         = VRAM_WORD_W,
  parameter  int WORDS_PER_LINE = VRAM_WORDS_PER_LINE,
  parameter  int LINES          = VRAM_LINES,
  localparam int LINE_W         = WORD_W * WORDS_PER_LINE,
  localparam int WIDX_W         = $clog2(WORDS_PER_LINE),
  localparam int LADDR_W        = $clog2(LINES)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       write_valid,
  output logic                       write_ready,
  input  logic [LADDR_W+WIDX_W-1:0]  write_addr,
  input  logic [WORD_W-1:0]          write_data,
  input  logic                       write_flush,
  input  logic [LADDR_W-1:0]         read_addr,
  output logic [LINE_W-1:0]          read_data,
  output logic                       busy,
  output logic [15:0]                commit_count
);

  packer_state_t             state;
  logic [WORDS_PER_LINE-1:0] mask;
  logic [WORDS_PER_LINE-1:0] word_bit;
  logic [WORDS_PER_LINE-1:0] next_mask;
  logic [LADDR_W-1:0]        line_tag;
  logic [LADDR_W-1:0]        wr_line;
  logic [WIDX_W-1:0]         wr_idx;
  logic [WORD_W-1:0]         line_buf [WORDS_PER_LINE];
  logic                      line_switch;
  logic                      accept;

  assign wr_line     = write_addr[LADDR_W+WIDX_W-1:WIDX_W];
  assign wr_idx      = write_addr[WIDX_W-1:0];

  // A word for another line is held off until the open line has been committed.
  assign line_switch = (state == PK_FILL) && write_valid && (wr_line != line_tag);
  assign write_ready = (state != PK_COMMIT) && !line_switch;
  assign accept      = write_valid && write_ready;
  assign word_bit    = {{(WORDS_PER_LINE-1){1'b0}}, 1'b1} << wr_idx;
  assign next_mask   = mask | (accept ? word_bit : '0);
  assign busy        = (state != PK_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= PK_IDLE;
      mask         <= '0;
      line_tag     <= '0;
      commit_count <= '0;
    end else begin
      case (state)
        PK_IDLE: begin
          if (accept) begin
            mask     <= next_mask;
            line_tag <= wr_line;
            state    <= PK_FILL;
          end
        end
        PK_FILL: begin
          mask <= next_mask;
          if (write_flush || line_switch || (&next_mask)) state <= PK_COMMIT;
        end
        PK_COMMIT: begin
          mask         <= '0;
          commit_count <= commit_count + 16'd1;
          state        <= PK_IDLE;
        end
        default: begin
          mask  <= '0;
          state <= PK_IDLE;
        end
      endcase
    end
  end

  // Buffer contents need no reset: an empty mask means nothing is ever committed from them.
  always_ff @(posedge clk) begin
    if (accept) line_buf[wr_idx] <= write_data;
  end

  // Word 0 lands in the MSBs of the read line.
  for (genvar i = 0; i < WORDS_PER_LINE; i++) begin : g_bank
    logic [WORD_W-1:0] bank_q;

    vram_word_bank #(
      .WORD_W (WORD_W),
      .LINES  (LINES)
    ) u_bank (
      .clk   (clk),
      .rst   (rst),
      .we    ((state == PK_COMMIT) && mask[i]),
      .waddr (line_tag),
      .wdata (line_buf[i]),
      .raddr (read_addr),
      .rdata (bank_q)
    );

    assign read_data[LINE_W-1-i*WORD_W -: WORD_W] = bank_q;
  end

endmodule

// File: tb/tb_vram_line_packer_memory.sv
// Directed bench for vram_line_packer_memory with hand-computed expected lines.
module tb_vram_line_packer_memory;

  localparam int WORD_W  = 16;
  localparam int WPL     = 16;
  localparam int LINES   = 2048;
  localparam int LINE_W  = WORD_W * WPL;
  localparam int WIDX_W  = 4;
  localparam int LADDR_W = 11;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic                      write_valid;
  logic                      write_ready;
  logic [LADDR_W+WIDX_W-1:0] write_addr;
  logic [WORD_W-1:0]         write_data;
  logic                      write_flush;
  logic [LADDR_W-1:0]        read_addr;
  logic [LINE_W-1:0]         read_data;
  logic                      busy;
  logic [15:0]               commit_count;

  int total  = 0;
  int passes = 0;

  vram_line_packer_memory #(
    .WORD_W         (WORD_W),
    .WORDS_PER_LINE (WPL),
    .LINES          (LINES)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .write_valid  (write_valid),
    .write_ready  (write_ready),
    .write_addr   (write_addr),
    .write_data   (write_data),
    .write_flush  (write_flush),
    .read_addr    (read_addr),
    .read_data    (read_data),
    .busy         (busy),
    .commit_count (commit_count)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkb(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic checkw(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic checkl(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [15:0] word_at(input logic [LINE_W-1:0] l, input int i);
    return l[LINE_W-1-i*WORD_W -: WORD_W];
  endfunction

  // Offers one word, waits (bounded) for ready, and lets it be accepted on the next edge.
  task automatic write_word(input logic [LADDR_W-1:0] line, input int idx,
                            input logic [WORD_W-1:0] d, output bit stalled);
    int n;
    n           = 0;
    write_valid = 1'b1;
    write_addr  = {line, idx[WIDX_W-1:0]};
    write_data  = d;
    #1;
    stalled = !write_ready;
    while (!write_ready && n < 20) begin
      tick();
      #1;
      n++;
    end
    if (n == 20) begin
      total++;
      $error("FAIL ready_timeout: write_ready %b expected 1", write_ready);
    end
    tick();
    write_valid = 1'b0;
  endtask

  initial begin
    logic [LINE_W-1:0] e;
    bit                st;
    bit                any_stall;

    write_valid = 1'b0;
    write_addr  = '0;
    write_data  = '0;
    write_flush = 1'b0;
    read_addr   = '0;

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkl("rst_read_data", read_data, '0);
    checkw("rst_commit_count", commit_count, 16'h0000);
    checkb("rst_busy", busy, 1'b0);
    rst = 1'b0;
    #1;
    checkb("rst_ready", write_ready, 1'b1);

    // 1: full line 5, back to back
    any_stall = 1'b0;
    for (int i = 0; i < 16; i++) begin
      write_word(11'd5, i, 16'(16'h1000 + i), st);
      any_stall = any_stall | st;
    end
    checkb("t1_no_stall", any_stall, 1'b0);
    checkb("t1_commit_busy", busy, 1'b1);
    checkb("t1_commit_ready", write_ready, 1'b0);
    checkw("t1_count_before", commit_count, 16'd0);
    tick();
    checkw("t1_count", commit_count, 16'd1);
    checkb("t1_idle_busy", busy, 1'b0);
    read_addr = 11'd5;
    tick();
    for (int i = 0; i < 16; i++) e[LINE_W-1-i*WORD_W -: WORD_W] = 16'(16'h1000 + i);
    checkl("t1_line5", read_data, e);

    // 2: preload line 9, then partial write + flush
    for (int i = 0; i < 16; i++) write_word(11'd9, i, 16'hFFFF, st);
    tick();
    checkw("t2_preload_count", commit_count, 16'd2);
    for (int i = 0; i < 4; i++) write_word(11'd9, i, 16'hAAAA, st);
    write_flush = 1'b1;
    tick();
    write_flush = 1'b0;
    checkb("t2_commit_ready", write_ready, 1'b0);
    tick();
    checkw("t2_count", commit_count, 16'd3);
    read_addr = 11'd9;
    tick();
    for (int i = 0; i < 16; i++) e[LINE_W-1-i*WORD_W -: WORD_W] = (i < 4) ? 16'hAAAA : 16'hFFFF;
    checkl("t2_line9", read_data, e);

    // 3: line switch 7 -> 8
    write_word(11'd7, 0, 16'h7000, st);
    write_word(11'd7, 1, 16'h7001, st);
    write_valid = 1'b1;
    write_addr  = {11'd8, 4'd0};
    write_data  = 16'h8000;
    #1;
    checkb("t3_ready_fill", write_ready, 1'b0);
    tick();
    #1;
    checkb("t3_ready_commit", write_ready, 1'b0);
    checkb("t3_busy_commit", busy, 1'b1);
    tick();
    #1;
    checkb("t3_ready_idle", write_ready, 1'b1);
    checkw("t3_count_line7", commit_count, 16'd4);
    tick();
    write_valid = 1'b0;
    checkb("t3_busy_line8", busy, 1'b1);
    write_flush = 1'b1;
    tick();
    write_flush = 1'b0;
    tick();
    checkw("t3_count_line8", commit_count, 16'd5);
    read_addr = 11'd7;
    tick();
    checkw("t3_line7_w0", word_at(read_data, 0), 16'h7000);
    checkw("t3_line7_w1", word_at(read_data, 1), 16'h7001);
    read_addr = 11'd8;
    tick();
    checkw("t3_line8_w0", word_at(read_data, 0), 16'h8000);

    // 5: read of the line being committed returns old data first
    write_word(11'd7, 0, 16'h7A00, st);
    write_flush = 1'b1;
    tick();
    write_flush = 1'b0;
    read_addr = 11'd7;
    tick();
    checkw("t5_read_old", word_at(read_data, 0), 16'h7000);
    tick();
    checkw("t5_read_new", word_at(read_data, 0), 16'h7A00);
    checkw("t5_count", commit_count, 16'd6);

    // 6a: duplicate index, last write wins, single commit
    for (int i = 0; i < 5; i++) write_word(11'd10, i, (i == 4) ? 16'h1111 : 16'(16'hA000 + i), st);
    write_word(11'd10, 4, 16'h2222, st);
    checkb("t6_dup_busy", busy, 1'b1);
    checkw("t6_dup_no_commit", commit_count, 16'd6);
    for (int i = 5; i < 16; i++) write_word(11'd10, i, 16'(16'hA000 + i), st);
    tick();
    read_addr = 11'd10;
    tick();
    checkw("t6_count", commit_count, 16'd7);
    for (int i = 0; i < 16; i++) e[LINE_W-1-i*WORD_W -: WORD_W] = (i == 4) ? 16'h2222 : 16'(16'hA000 + i);
    checkl("t6_line10", read_data, e);

    // 6b: commit counter wrap
    force dut.commit_count = 16'hFFFF;
    tick();
    release dut.commit_count;
    #1;
    checkw("t6_wrap_preset", commit_count, 16'hFFFF);
    write_word(11'd11, 0, 16'h1234, st);
    write_flush = 1'b1;
    tick();
    write_flush = 1'b0;
    tick();
    checkw("t6_wrap", commit_count, 16'h0000);

    // 4: reset in the middle of a fill discards the line
    for (int i = 0; i < 16; i++) write_word(11'd3, i, 16'(16'h3000 + i), st);
    tick();
    for (int i = 0; i < 10; i++) write_word(11'd3, i, 16'hDEAD, st);
    rst = 1'b1;
    #1;
    checkl("t4_rst_read_data", read_data, '0);
    checkw("t4_rst_count", commit_count, 16'd0);
    checkb("t4_rst_busy", busy, 1'b0);
    tick();
    rst = 1'b0;
    #1;
    checkb("t4_ready", write_ready, 1'b1);
    read_addr = 11'd3;
    tick();
    tick();
    for (int i = 0; i < 16; i++) e[LINE_W-1-i*WORD_W -: WORD_W] = 16'(16'h3000 + i);
    checkl("t4_line3_unchanged", read_data, e);
    checkw("t4_count_after", commit_count, 16'd0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
